// File: rtl/lsu_ctrl.sv
// Load/store control: one request at a time, fault screening on accept,
// a LATENCY-stretched data-memory access and a held response.
module lsu_ctrl #(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned LATENCY   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        rsp_access_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    typedef struct packed {
        logic [31:0] off;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  funct3;
    } req_t;

    state_t      state, state_nxt;
    req_t        cap;
    logic [3:0]  cnt;
    logic        f3_legal, misalign, range_err, fault, accept;
    logic [32:0] offset33, size33, end33;

    // Fault screening runs on the incoming request, not the captured copy.
    always_comb begin
        if (req_we)
            f3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (req_funct3[1:0])
            2'b00:   size33 = 33'd1;
            2'b01:   size33 = 33'd2;
            default: size33 = 33'd4;
        endcase
        misalign = f3_legal &&
                   ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00));
        offset33  = {1'b0, req_addr} - {1'b0, MEM_BASE};
        end33     = offset33 + size33;
        range_err = f3_legal && !misalign &&
                    ((req_addr < MEM_BASE) || (end33 > 33'(MEM_BYTES)));
        fault     = !f3_legal || misalign || range_err;
        accept    = req_valid && (state == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fault ? RESP : ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        rsp_valid  = (state == RESP);
        mem_read   = (state == ACCESS) && !cap.we;
        mem_write  = (state == ACCESS) && cap.we && (cnt == 4'd0);
        mem_addr   = cap.off;
        mem_wdata  = cap.wdata;
        mem_funct3 = cap.funct3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap            <= '0;
            cnt            <= 4'd0;
            rsp_rdata      <= 32'd0;
            rsp_misalign   <= 1'b0;
            rsp_access_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cap            <= '{off: offset33[31:0], wdata: req_wdata,
                                        we: req_we, funct3: req_funct3};
                    cnt            <= fault ? 4'd0 : 4'(LATENCY);
                    rsp_rdata      <= 32'd0;
                    rsp_misalign   <= misalign;
                    rsp_access_err <= !f3_legal || range_err;
                end
                ACCESS: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else             rsp_rdata <= cap.we ? 32'd0 : mem_rdata;
                end
                RESP: if (rsp_ready) begin
                    rsp_rdata      <= 32'd0;
                    rsp_misalign   <= 1'b0;
                    rsp_access_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: three configurations, each with its own
// byte-array memory, a reference model and a decoupled response monitor.
module tb_lsu_ctrl;

    localparam int N = 3;
    localparam int          LATS  [N] = '{0, 3, 0};
    localparam logic [31:0] BASES [N] = '{32'h0, 32'h0, 32'h8000_0000};
    localparam int MBYTES = 4096;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        aerr;
        int          lat;
        int          wr;
        int          rd;
    } exp_t;

    logic clk, rst;
    logic        rv [N], rr [N], we [N], vv [N], vr [N], mis [N], aerr [N], mw [N], mr [N];
    logic [31:0] ra [N], wd [N], rd [N], ma [N], mwd [N], mrd [N];
    logic [2:0]  f3 [N], mf3 [N];

    logic [7:0] ref_mem [N][MBYTES];
    exp_t       sbq [N][$];
    bit         bp_hold [N];
    bit         rand_mode;
    int         nchk, npass, ncyc;
    int         acc [N], wcnt [N], rcnt [N];
    bit         pv [N];
    logic [31:0] hold_r [N];
    logic [1:0]  hold_f [N];

    function automatic logic [31:0] fmt(input logic [2:0] f, input logic [7:0] b0, b1, b2, b3);
        case (f)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'd0, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : gd
        logic [7:0] m [MBYTES];

        lsu_ctrl #(.MEM_BASE(BASES[g]), .MEM_BYTES(MBYTES), .LATENCY(LATS[g])) dut (
            .clk(clk), .rst(rst),
            .req_valid(rv[g]), .req_ready(rr[g]), .req_addr(ra[g]), .req_wdata(wd[g]),
            .req_we(we[g]), .req_funct3(f3[g]),
            .rsp_valid(vv[g]), .rsp_ready(vr[g]), .rsp_rdata(rd[g]),
            .rsp_misalign(mis[g]), .rsp_access_err(aerr[g]),
            .mem_addr(ma[g]), .mem_wdata(mwd[g]), .mem_write(mw[g]), .mem_read(mr[g]),
            .mem_funct3(mf3[g]), .mem_rdata(mrd[g])
        );

        initial for (int k = 0; k < MBYTES; k++) m[k] = 8'h00;

        always @(posedge clk) if (mw[g]) begin
            m[ma[g][11:0]] <= mwd[g][7:0];
            if (mf3[g][1:0] != 2'b00) m[ma[g][11:0] + 12'd1] <= mwd[g][15:8];
            if (mf3[g][1]) begin
                m[ma[g][11:0] + 12'd2] <= mwd[g][23:16];
                m[ma[g][11:0] + 12'd3] <= mwd[g][31:24];
            end
        end

        assign mrd[g] = fmt(mf3[g], m[ma[g][11:0]], m[ma[g][11:0] + 12'd1],
                            m[ma[g][11:0] + 12'd2], m[ma[g][11:0] + 12'd3]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp_v);
        nchk++;
        if (act === exp_v) npass++;
        else $display("FAIL %s dut%0d: got %h, expected %h", nm, i, act, exp_v);
    endtask

    // Reference model: spec rules in plain integer arithmetic over a byte array.
    function automatic exp_t predict(input int i, input logic [31:0] a, input logic w,
                                     input logic [2:0] f);
        exp_t   e;
        bit     legal;
        longint ua, off, size, val;
        legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
        size  = longint'(1) << f[1:0];
        ua    = longint'({32'd0, a});
        off   = ua - longint'({32'd0, BASES[i]});
        e.mis  = legal && ((ua % size) != 0);
        e.aerr = !legal || (!e.mis && (off < 0 || off + size > MBYTES));
        e.rdata = 32'd0;
        if (!e.mis && !e.aerr && !w) begin
            val = 0;
            for (int k = 0; k < int'(size); k++)
                val += longint'(ref_mem[i][int'(off) + k]) << (8 * k);
            if (f == 3'd0 && val >= 128)   val -= 256;
            if (f == 3'd1 && val >= 32768) val -= 65536;
            e.rdata = val[31:0];
        end
        e.lat = (e.mis || e.aerr) ? 1 : LATS[i] + 2;
        e.wr  = (!e.mis && !e.aerr && w) ? 1 : 0;
        e.rd  = (!e.mis && !e.aerr && !w) ? LATS[i] + 1 : 0;
        return e;
    endfunction

    task automatic issue(input int i, input logic [31:0] a, input logic w, input logic [2:0] f,
                         input logic [31:0] d, input bit commit = 1'b1);
        exp_t e;
        int   t;
        longint off;
        e = predict(i, a, w, f);
        @(posedge clk); #1;
        ra[i] = a; wd[i] = d; we[i] = w; f3[i] = f; rv[i] = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (rr[i]) break;
            if (++t > 200) begin
                nchk++; $display("FAIL accept_timeout dut%0d: got busy, expected ready", i);
                rv[i] = 1'b0;
                return;
            end
        end
        sbq[i].push_back(e);
        if (commit && e.wr == 1) begin
            off = longint'({32'd0, a}) - longint'({32'd0, BASES[i]});
            for (int k = 0; k < (1 << f[1:0]); k++) ref_mem[i][int'(off) + k] = d[8*k +: 8];
        end
        @(posedge clk); #1;
        rv[i] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq[0].size() + sbq[1].size() + sbq[2].size() != 0) begin
            @(negedge clk);
            if (++t > 1000) begin
                nchk++; $display("FAIL drain_timeout: got pending responses, expected none");
                return;
            end
        end
        @(negedge clk);
    endtask

    // Hold off the consumer and offer a stray request while a response waits.
    task automatic hold_bp(input int i);
        int t = 0;
        while (!vv[i]) begin
            @(negedge clk);
            if (++t > 50) begin
                nchk++; $display("FAIL rsp_timeout dut%0d: got no rsp_valid, expected one", i);
                return;
            end
        end
        @(posedge clk); #1;
        ra[i] = 32'h44; we[i] = 1'b0; f3[i] = 3'b010; rv[i] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_req_ready", i, 32'(rr[i]), 32'd0);
            chk("bp_rsp_valid", i, 32'(vv[i]), 32'd1);
        end
        @(posedge clk); #1;
        rv[i] = 1'b0;
        bp_hold[i] = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++)
            vr[i] = bp_hold[i] ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                wcnt[i] = 0; rcnt[i] = 0; pv[i] = 1'b0;
                continue;
            end
            if (rv[i] && rr[i]) acc[i] = ncyc;
            if (mw[i]) begin
                wcnt[i]++;
                chk("write_pos", i, 32'(ncyc - acc[i]), 32'(LATS[i] + 1));
            end
            if (mr[i]) rcnt[i]++;
            if (vv[i]) begin
                if (sbq[i].size() == 0) begin
                    nchk++;
                    $display("FAIL unexpected_rsp dut%0d: got rsp_valid, expected none", i);
                end else begin
                    e = sbq[i][0];
                    if (!pv[i]) begin
                        chk("latency", i, 32'(ncyc - acc[i]), 32'(e.lat));
                        hold_r[i] = rd[i];
                        hold_f[i] = {mis[i], aerr[i]};
                    end else begin
                        chk("stable_rdata", i, rd[i], hold_r[i]);
                        chk("stable_flags", i, 32'({mis[i], aerr[i]}), 32'(hold_f[i]));
                    end
                    pv[i] = 1'b1;
                    if (vr[i]) begin
                        chk("rdata", i, rd[i], e.rdata);
                        chk("misalign", i, 32'(mis[i]), 32'(e.mis));
                        chk("access_err", i, 32'(aerr[i]), 32'(e.aerr));
                        chk("write_cycles", i, 32'(wcnt[i]), 32'(e.wr));
                        chk("read_cycles", i, 32'(rcnt[i]), 32'(e.rd));
                        void'(sbq[i].pop_front());
                        wcnt[i] = 0; rcnt[i] = 0; pv[i] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $display("%0d/%0d checks passed", npass, nchk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int          r;
        rst = 1'b1; rand_mode = 1'b0; ncyc = 0; nchk = 0; npass = 0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0; ra[i] = '0; wd[i] = '0; we[i] = 1'b0; f3[i] = '0;
            bp_hold[i] = 1'b0; acc[i] = 0; wcnt[i] = 0; rcnt[i] = 0; pv[i] = 1'b0;
            for (int k = 0; k < MBYTES; k++) ref_mem[i][k] = 8'h00;
        end
        #3;
        for (int i = 0; i < N; i++) begin
            chk("rst_req_ready", i, 32'(rr[i]), 32'd1);
            chk("rst_rsp_valid", i, 32'(vv[i]), 32'd0);
            chk("rst_rdata", i, rd[i], 32'd0);
            chk("rst_flags", i, 32'({mis[i], aerr[i]}), 32'd0);
            chk("rst_enables", i, 32'({mr[i], mw[i]}), 32'd0);
            chk("rst_mem_addr", i, ma[i], 32'd0);
            chk("rst_mem_wdata", i, mwd[i], 32'd0);
            chk("rst_mem_funct3", i, 32'(mf3[i]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // LATENCY 0: round trip, sub-word, misalign, range/funct3
        issue(0, 32'h100, 1, 3'b010, 32'hDEAD_BEEF);
        issue(0, 32'h100, 0, 3'b010, 32'h0);
        issue(0, 32'h0,   1, 3'b000, 32'h80);
        issue(0, 32'h0,   0, 3'b000, 32'h0);
        issue(0, 32'h0,   0, 3'b100, 32'h0);
        issue(0, 32'h2,   1, 3'b001, 32'h8001);
        issue(0, 32'h2,   0, 3'b001, 32'h0);
        issue(0, 32'h102, 0, 3'b010, 32'h0);
        issue(0, 32'h101, 1, 3'b001, 32'h1234);
        issue(0, 32'h3,   0, 3'b001, 32'h0);
        issue(0, 32'h3,   0, 3'b000, 32'h0);
        issue(0, 32'hFFC, 0, 3'b010, 32'h0);
        issue(0, 32'h1000, 0, 3'b010, 32'h0);
        issue(0, 32'hFFF, 0, 3'b001, 32'h0);
        issue(0, 32'hFFE, 0, 3'b101, 32'h0);
        issue(0, 32'h10,  1, 3'b100, 32'h55);
        // MEM_BASE 0x8000_0000
        issue(2, 32'h7FFF_FFFC, 0, 3'b010, 32'h0);
        issue(2, 32'h8000_0100, 1, 3'b010, 32'h0BAD_F00D);
        issue(2, 32'h8000_0100, 0, 3'b010, 32'h0);
        issue(2, 32'h8000_1000, 0, 3'b000, 32'h0);
        issue(2, 32'hFFFF_FFFF, 0, 3'b000, 32'h0);
        drain();

        // LATENCY 3: backpressure on a store and a load
        bp_hold[1] = 1'b1;
        issue(1, 32'h40, 1, 3'b010, 32'hA5A5_5A5A);
        hold_bp(1);
        drain();
        bp_hold[1] = 1'b1;
        issue(1, 32'h40, 0, 3'b010, 32'h0);
        hold_bp(1);
        drain();

        // Reset in the second ACCESS cycle of a store aborts it
        issue(1, 32'h200, 1, 3'b010, 32'h1234_5678, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_req_ready", 1, 32'(rr[1]), 32'd1);
        chk("abort_rsp_valid", 1, 32'(vv[1]), 32'd0);
        chk("abort_enables", 1, 32'({mr[1], mw[1]}), 32'd0);
        chk("abort_mem_addr", 1, ma[1], 32'd0);
        chk("abort_mem_wdata", 1, mwd[1], 32'd0);
        sbq[1].delete();
        @(negedge clk); @(posedge clk); #1;
        rst = 1'b0;
        issue(1, 32'h200, 0, 3'b010, 32'h0);
        drain();

        // Random mix with a throttled consumer
        rand_mode = 1'b1;
        for (int n = 0; n < 360; n++) begin
            int i;
            i = n % N;
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASES[i] + $urandom_range(0, MBYTES - 1);
            else if (r == 7) a = BASES[i] + 32'(MBYTES - 4) + $urandom_range(0, 7);
            else if (r == 8) a = BASES[i] - $urandom_range(1, 4);
            else             a = $urandom;
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8) begin
                r = $urandom_range(0, 4);
                f = (r == 3) ? 3'b100 : (r == 4) ? 3'b101 : 3'(r);
            end
            issue(i, a, 1'($urandom_range(0, 1)), f, $urandom);
        end
        drain();
        rand_mode = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
